first_nios2_system_sysid_arb: RTL
=================================

// Module: first_nios2_system_sysid_arb
// PURPOSE
//  Two-master read arbiter and sequencer for the system-ID control slave.
//  Accepts Avalon-MM reads from two masters (CPU data master, JTAG debug master).
//  Grants one at a time, round-robin, and drives the slave's 1-bit address.
//  Waits a fixed read latency, registers readdata and returns it with readdatavalid.
//  Sits between the interconnect and the combinational sysid slave.
// PARAMETERS
//  READ_LATENCY  1   slave settle cycles before readdata is captured; legal 1..8
//  DATA_W        32  readdata width
// PORTS
//  clock             in   1       system clock; all flops on rising edge
//  reset_n           in   1       asynchronous active-low reset
//  m0_address        in   1       master 0 word address (0 = ID, 1 = timestamp)
//  m0_read           in   1       master 0 read request; held until accepted
//  m0_waitrequest    out  1       master 0 stall; low in the acceptance cycle only
//  m0_readdata       out  DATA_W  master 0 read data; valid with m0_readdatavalid
//  m0_readdatavalid  out  1       master 0 one-cycle response strobe
//  m1_*              (same five signals as m0_*, for master 1)
//  s_address         out  1       address to sysid slave
//  s_readdata        in   DATA_W  combinational readdata from sysid slave
// BEHAVIOUR
//  - Reset (reset_n low, any time, async):
//    state=IDLE, armed=0, rr_last=1, addr_q=0, rdata_q=0.
//    All waitrequest=1, readdatavalid=0, readdata=0, s_address=0.
//  - armed sets on the first clock after reset release.
//    While armed=0, no request is accepted.
//  - FSM states: IDLE -> WAIT -> DONE -> IDLE.
//    - IDLE: if armed and any mX_read, pick a winner.
//      Winner's waitrequest=0 combinationally in this cycle (acceptance cycle T).
//      Latch its address into addr_q and its id into owner.
//      Set rr_last=owner, cnt=READ_LATENCY-1, go to WAIT.
//    - WAIT: s_address=addr_q. If cnt==0: rdata_q<=s_readdata, go to DONE.
//      Otherwise cnt<=cnt-1.
//    - DONE: owner's readdatavalid=1 and readdata=rdata_q for one cycle; go to IDLE.
//  - Timing: readdatavalid at cycle T+READ_LATENCY+1.
//    Next acceptance earliest at T+READ_LATENCY+2. One read outstanding maximum.
//  - Arbitration:
//    - Only one master reading: that master wins.
//    - Both reading: master != rr_last wins. First tie after reset goes to m0.
//  - waitrequest is 1 in every cycle that is not that master's acceptance cycle.
//    This includes WAIT/DONE and cycles where the master is not reading.
//  - mX_readdata holds rdata_q at all times. Only readdatavalid qualifies it.
//    The non-owner never sees readdatavalid.
//  - s_address holds addr_q in all states; changes only on acceptance.
//  - A master dropping read before acceptance is ignored (protocol violation).
//    No state is affected.
//  - Reset during WAIT/DONE aborts the read. No readdatavalid is produced.
//  - cnt is 3 bits. READ_LATENCY outside 1..8 is a compile-time error (generate check).
// CONFIGURATION
//  SYSID_ARB_LOCK_EN defined:
//   - Adds inputs m0_lock, m1_lock (1 bit each), sampled at acceptance.
//   - If the owner's lock=1 at acceptance, lock_q=owner.
//   - While lock_q is set, in IDLE only master lock_q may be accepted.
//     The other master stalls even if reading.
//   - lock_q clears when the locked master is accepted with lock=0.
//     It also clears when that master's read is low for an armed IDLE cycle, and on reset.
//  SYSID_ARB_LOCK_EN undefined:
//   - No lock ports, no lock_q. Pure round-robin as above.
// TESTING (bench slave model: s_readdata = s_address ? 32'h511E3EFA : 32'h0; READ_LATENCY=1 unless noted)
//  1. Reset release; m0_read=1, addr=1 at first armed cycle T
//     -> m0_waitrequest=0 at T; m0_readdatavalid=1 at T+2 with data 32'h511E3EFA.
//  2. m0 and m1 both read continuously, addr 0 and 1
//     -> grants alternate m0,m1,m0,m1; one accept every 3 cycles.
//     Each master receives only its own data (0 / 32'h511E3EFA).
//  3. READ_LATENCY=4; m1 reads addr 1 at T
//     -> s_address=1 from T+1; m1_readdatavalid only at T+5; m0_readdatavalid never asserts.
//  4. Assert reset_n low at T+1 after an m0 accept at T
//     -> no readdatavalid; all waitrequest=1 during reset.
//     First post-reset tie is granted to m0.
//  5. SYSID_ARB_LOCK_EN: m1 accepted with lock=1, m0 and m1 both reading
//     -> m1 is granted 3 consecutive times while lock=1; m0 is granted at the first IDLE after an m1 accept with lock=0.
//  6. Master read low in all cycles -> waitrequest stays 1, FSM stays IDLE, s_address stays unchanged.

Source files
------------

// File: rtl/first_nios2_system_sysid_arb.sv
// ---------------------------------------------------------------------------
// first_nios2_system_sysid_arb
// Two-master round-robin read arbiter and sequencer in front of the
// combinational system-ID slave. One read is outstanding at a time. The
// winner is stalled low only in its acceptance cycle. After READ_LATENCY
// settle cycles, readdata is captured and returned to the owner with a
// one-cycle readdatavalid strobe.
//
// Optional feature macro: SYSID_ARB_LOCK_EN
//   Adds m0_lock/m1_lock. A master accepted with lock=1 keeps exclusive
//   access until it is accepted with lock=0, or until it leaves read low
//   during an armed idle cycle.
//
// Ports
//   clock, reset_n          clock; asynchronous active-low reset
//   mX_address, mX_read     master X word address and read request
//   mX_lock                 master X lock request (SYSID_ARB_LOCK_EN only)
//   mX_waitrequest          master X stall; low only in its acceptance cycle
//   mX_readdata             captured read data, qualified by mX_readdatavalid
//   mX_readdatavalid        master X one-cycle response strobe
//   s_address, s_readdata   sysid slave address out, combinational data in
// ---------------------------------------------------------------------------
module first_nios2_system_sysid_arb #(
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned DATA_W       = 32
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              m0_address,
    input  logic              m0_read,
`ifdef SYSID_ARB_LOCK_EN
    input  logic              m0_lock,
`endif
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,
    input  logic              m1_address,
    input  logic              m1_read,
`ifdef SYSID_ARB_LOCK_EN
    input  logic              m1_lock,
`endif
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,
    output logic              s_address,
    input  logic [DATA_W-1:0] s_readdata
);

    localparam int unsigned CNT_W = 3;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(READ_LATENCY - 1);

    // Reject latencies the 3-bit counter cannot express.
    if (READ_LATENCY < 1 || READ_LATENCY > 8) begin : g_lat_chk
        $error("READ_LATENCY must be in 1..8");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_armed;
    logic                r_rr_last;
    logic                w_rr_last_nxt;
    logic                r_addr_q;
    logic                w_addr_nxt;
    logic                r_owner;
    logic                w_owner_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic [DATA_W-1:0]   r_rdata_q;
    logic [DATA_W-1:0]   w_rdata_nxt;

    logic                w_elig0;
    logic                w_elig1;
    logic                w_accept;
    logic                w_winner;
    logic                w_wait0;
    logic                w_wait1;
    logic                w_rdv0;
    logic                w_rdv1;

`ifdef SYSID_ARB_LOCK_EN
    logic                r_lock_vld;
    logic                r_lock_id;
    logic                w_lock_vld_nxt;
    logic                w_lock_id_nxt;
`endif

    // Eligibility: a held lock restricts acceptance to the locking master.
    always_comb begin
        w_elig0 = m0_read;
        w_elig1 = m1_read;
`ifdef SYSID_ARB_LOCK_EN
        if (r_lock_vld) begin
            w_elig0 = m0_read & ~r_lock_id;
            w_elig1 = m1_read &  r_lock_id;
        end
`endif
        w_accept = r_armed && (r_state == ST_IDLE) && (w_elig0 || w_elig1);
        // On a tie the master that did not win last time goes next.
        w_winner = (w_elig0 && w_elig1) ? ~r_rr_last : w_elig1;
    end

    // Next-state and output decode.
    always_comb begin
        w_state_nxt   = r_state;
        w_rr_last_nxt = r_rr_last;
        w_addr_nxt    = r_addr_q;
        w_owner_nxt   = r_owner;
        w_cnt_nxt     = r_cnt;
        w_rdata_nxt   = r_rdata_q;
        w_wait0       = 1'b1;
        w_wait1       = 1'b1;
        w_rdv0        = 1'b0;
        w_rdv1        = 1'b0;
`ifdef SYSID_ARB_LOCK_EN
        w_lock_vld_nxt = r_lock_vld;
        w_lock_id_nxt  = r_lock_id;
`endif
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_wait0       = w_winner;
                    w_wait1       = ~w_winner;
                    w_addr_nxt    = w_winner ? m1_address : m0_address;
                    w_owner_nxt   = w_winner;
                    w_rr_last_nxt = w_winner;
                    w_cnt_nxt     = CNT_INIT;
                    w_state_nxt   = ST_WAIT;
`ifdef SYSID_ARB_LOCK_EN
                    // Winner is always the lock holder while locked, so this
                    // both takes and releases the lock.
                    w_lock_vld_nxt = w_winner ? m1_lock : m0_lock;
                    w_lock_id_nxt  = w_winner;
`endif
                end
`ifdef SYSID_ARB_LOCK_EN
                else if (r_armed && r_lock_vld &&
                         !(r_lock_id ? m1_read : m0_read)) begin
                    // Lock holder went away; release exclusivity.
                    w_lock_vld_nxt = 1'b0;
                end
`endif
            end
            ST_WAIT: begin
                if (r_cnt == '0) begin
                    w_rdata_nxt = s_readdata;
                    w_state_nxt = ST_DONE;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            ST_DONE: begin
                w_rdv0      = ~r_owner;
                w_rdv1      = r_owner;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_armed   <= 1'b0;
            r_rr_last <= 1'b1;
            r_addr_q  <= 1'b0;
            r_owner   <= 1'b0;
            r_cnt     <= '0;
            r_rdata_q <= '0;
`ifdef SYSID_ARB_LOCK_EN
            r_lock_vld <= 1'b0;
            r_lock_id  <= 1'b0;
`endif
        end else begin
            r_state   <= w_state_nxt;
            r_armed   <= 1'b1;
            r_rr_last <= w_rr_last_nxt;
            r_addr_q  <= w_addr_nxt;
            r_owner   <= w_owner_nxt;
            r_cnt     <= w_cnt_nxt;
            r_rdata_q <= w_rdata_nxt;
`ifdef SYSID_ARB_LOCK_EN
            r_lock_vld <= w_lock_vld_nxt;
            r_lock_id  <= w_lock_id_nxt;
`endif
        end
    end

    // Readdata is always the captured word; only readdatavalid qualifies it.
    assign m0_waitrequest   = w_wait0;
    assign m1_waitrequest   = w_wait1;
    assign m0_readdatavalid = w_rdv0;
    assign m1_readdatavalid = w_rdv1;
    assign m0_readdata      = r_rdata_q;
    assign m1_readdata      = r_rdata_q;
    assign s_address        = r_addr_q;

endmodule
